// File: rtl/cirno9_ram_resp.sv
// cirno9 load/store port responder: drives a 1-port sync SRAM with optional wait states.
// Optional byte-enable legality check enabled by defining CIRNO9_RAM_RESP_ALIGN_CHK_EN.
module cirno9_ram_resp #(
  parameter int unsigned SRAM_AW  = 10,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req_ren,
  input  logic [3:0]         i_req_wen,
  input  logic [31:0]        i_req_adr,
  input  logic [31:0]        i_req_wdat,
  output logic               o_req_rdy,
  output logic [31:0]        o_rsp_rdat,
  output logic               o_rsp_err,
  output logic               o_sram_en,
  output logic [3:0]         o_sram_we,
  output logic [SRAM_AW-1:0] o_sram_adr,
  output logic [31:0]        o_sram_din,
  input  logic [31:0]        i_sram_dout
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rd_q;
  logic          err_q;
  logic          req_c;
  logic          wen_ok_c;
  logic          adr_unused_c;

  assign req_c = i_req_ren | (|i_req_wen);

  // Byte-address LSBs and bits above the SRAM window are deliberately dropped.
  assign adr_unused_c = ^{i_req_adr[31:SRAM_AW+2], i_req_adr[1:0]};

`ifdef CIRNO9_RAM_RESP_ALIGN_CHK_EN
  // Only naturally aligned byte, halfword and word lane patterns are legal.
  always_comb begin
    wen_ok_c = 1'b0;
    case (i_req_wen)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: wen_ok_c = 1'b1;
      default:                            wen_ok_c = 1'b0;
    endcase
  end
`else
  assign wen_ok_c = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      o_req_rdy  <= 1'b0;
      o_rsp_rdat <= '0;
      o_rsp_err  <= 1'b0;
      o_sram_en  <= 1'b0;
      o_sram_we  <= '0;
      o_sram_adr <= '0;
      o_sram_din <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_c) begin
            // SRAM controls are registered here so they are valid throughout ACC.
            state      <= ACC;
            rd_q       <= i_req_ren & ~(|i_req_wen);
            err_q      <= ~wen_ok_c;
            o_sram_en  <= wen_ok_c;
            o_sram_we  <= wen_ok_c ? i_req_wen : 4'b0000;
            o_sram_adr <= i_req_adr[SRAM_AW+1:2];
            o_sram_din <= i_req_wdat;
          end
        end
        ACC: begin
          state      <= WAIT;
          cnt        <= CW'(WAIT_CYC);
          o_sram_en  <= 1'b0;
          o_sram_we  <= '0;
          o_sram_adr <= '0;
          o_sram_din <= '0;
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            if (rd_q) o_rsp_rdat <= i_sram_dout;
            o_req_rdy <= 1'b1;
            o_rsp_err <= err_q;
            state     <= RESP;
          end
        end
        RESP: begin
          o_req_rdy <= 1'b0;
          o_rsp_err <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cirno9_ram_resp.sv
// Bench for cirno9_ram_resp: two instances (WAIT_CYC 0 and 3), each with an SRAM model.
module tb_cirno9_ram_resp;

  localparam int unsigned SAW = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           ren  [2];
  logic [3:0]     wen  [2];
  logic [31:0]    adr  [2];
  logic [31:0]    wdat [2];
  logic           rdy  [2];
  logic [31:0]    rdat [2];
  logic           err  [2];
  logic           sen  [2];
  logic [3:0]     swe  [2];
  logic [SAW-1:0] sadr [2];
  logic [31:0]    sdin [2];

  typedef struct {
    logic [31:0] rdat;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] shadow [2][1024];
  logic [31:0] last_rdat [2];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [1024];
    logic [31:0] dout;

    cirno9_ram_resp #(.SRAM_AW(SAW), .WAIT_CYC((g == 0) ? 0 : 3)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_req_ren  (ren[g]),
      .i_req_wen  (wen[g]),
      .i_req_adr  (adr[g]),
      .i_req_wdat (wdat[g]),
      .o_req_rdy  (rdy[g]),
      .o_rsp_rdat (rdat[g]),
      .o_rsp_err  (err[g]),
      .o_sram_en  (sen[g]),
      .o_sram_we  (swe[g]),
      .o_sram_adr (sadr[g]),
      .o_sram_din (sdin[g]),
      .i_sram_dout(dout)
    );

    always @(posedge clk) begin
      if (sen[g]) begin
        for (int k = 0; k < 4; k++)
          if (swe[g][k]) mem[sadr[g]][8*k +: 8] <= sdin[g][8*k +: 8];
        if (swe[g] == 4'b0000) dout <= mem[sadr[g]];
      end
    end
  end

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic legal(input logic [3:0] w);
`ifdef CIRNO9_RAM_RESP_ALIGN_CHK_EN
    case (w)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                            return 1'b0;
    endcase
`else
    return (w === w);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check({tag, "_rdy"},  32'(rdy[d]),  32'h0);
    check({tag, "_rdat"}, rdat[d],      32'h0);
    check({tag, "_err"},  32'(err[d]),  32'h0);
    check({tag, "_en"},   32'(sen[d]),  32'h0);
    check({tag, "_we"},   32'(swe[d]),  32'h0);
    check({tag, "_adr"},  32'(sadr[d]), 32'h0);
    check({tag, "_din"},  sdin[d],      32'h0);
  endtask

  task automatic pop_and_compare(input int d, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'h1);
    end else begin
      e = sb.pop_front();
      check({tag, "_rdat"}, rdat[d], e.rdat);
      check({tag, "_err"}, 32'(err[d]), 32'(e.err));
    end
  endtask

  // One request from the IDLE cycle through RESP, checking SRAM drive and latency.
  task automatic xact(input int d, input logic r, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int unsigned word;
    logic        ok;
    int          cyc;
    word = 32'(a[SAW+1:2]);
    ok   = legal(w);
    if (w != 4'b0000) begin
      if (ok)
        for (int k = 0; k < 4; k++)
          if (w[k]) shadow[d][word][8*k +: 8] = wd[8*k +: 8];
      e.rdat = last_rdat[d];
    end else begin
      e.rdat       = shadow[d][word];
      last_rdat[d] = e.rdat;
    end
    e.err = ~ok;
    sb.push_back(e);
    ren[d] = r; wen[d] = w; adr[d] = a; wdat[d] = wd;
    tick();
    check("acc_en", 32'(sen[d]), 32'(ok));
    check("acc_we", 32'(swe[d]), ok ? 32'(w) : 32'h0);
    if (ok) begin
      check("acc_adr", 32'(sadr[d]), word);
      check("acc_din", sdin[d], wd);
    end
    tick();
    check("wait_en", 32'(sen[d]), 32'h0);
    for (cyc = 2; cyc < 12 + wc(d); cyc++) begin
      if (rdy[d] === 1'b1) break;
      tick();
    end
    check("rdy_cycle", 32'(cyc), 32'(3 + wc(d)));
    pop_and_compare(d, "rsp");
    ren[d] = 1'b0; wen[d] = 4'b0000;
    tick();
    check("rdy_pulse", 32'(rdy[d]), 32'h0);
  endtask

  // Read held continuously: pulses must be exactly 4+WAIT_CYC apart.
  task automatic b2b(input int d, input logic [31:0] a, input int n);
    int   per;
    int   last;
    int   pulses;
    int   extra;
    exp_t e;
    per    = 4 + wc(d);
    last   = -1;
    pulses = 0;
    extra  = 0;
    for (int i = 0; i < n; i++) begin
      e.rdat = shadow[d][32'(a[SAW+1:2])];
      e.err  = 1'b0;
      sb.push_back(e);
    end
    last_rdat[d] = shadow[d][32'(a[SAW+1:2])];
    ren[d] = 1'b1; wen[d] = 4'b0000; adr[d] = a;
    for (int c = 1; c <= n * per + 4 && pulses < n; c++) begin
      tick();
      if (rdy[d] === 1'b1) begin
        pulses++;
        check("b2b_gap", 32'(c - last), 32'(per));
        last = c;
        pop_and_compare(d, "b2b");
        if (pulses == n) ren[d] = 1'b0;
      end
    end
    check("b2b_count", 32'(pulses), 32'(n));
    ren[d] = 1'b0;
    for (int c = 0; c < 2 * per; c++) begin
      tick();
      if (rdy[d] === 1'b1) extra++;
    end
    check("b2b_extra", 32'(extra), 32'h0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ren[d] = 1'b0; wen[d] = 4'b0000; adr[d] = '0; wdat[d] = '0;
      last_rdat[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");
    rst = 1'b0;
    tick();

    // WAIT_CYC = 0 instance
    xact(0, 1'b0, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF);
    xact(0, 1'b1, 4'b0000, 32'h0000_0010, 32'h0);
    xact(0, 1'b0, 4'b0100, 32'h0000_0010, 32'h00AA_0000);
    xact(0, 1'b1, 4'b0000, 32'h0000_0010, 32'h0);
    xact(0, 1'b0, 4'b0101, 32'h0000_0010, 32'h1122_3344);
    xact(0, 1'b1, 4'b0000, 32'h0000_0010, 32'h0);
    xact(0, 1'b0, 4'b1111, 32'h0000_0FFC, 32'hCAFE_F00D);
    xact(0, 1'b1, 4'b0000, 32'h0000_7FFF, 32'h0);
    xact(0, 1'b1, 4'b1111, 32'h0000_0020, 32'h5A5A_5A5A);
    xact(0, 1'b1, 4'b0000, 32'h0000_0020, 32'h0);
    xact(0, 1'b0, 4'b0011, 32'h0000_0020, 32'h0000_1234);
    xact(0, 1'b1, 4'b0000, 32'h0000_0020, 32'h0);
    b2b(0, 32'h0000_0010, 3);

    // WAIT_CYC = 3 instance, including address wrap
    xact(1, 1'b0, 4'b1111, 32'h0000_0010, 32'h1234_5678);
    xact(1, 1'b1, 4'b0000, 32'h0000_1010, 32'h0);
    xact(1, 1'b0, 4'b1000, 32'h0000_1013, 32'h9900_0000);
    xact(1, 1'b1, 4'b0000, 32'h0000_0010, 32'h0);
    b2b(1, 32'h0000_1010, 2);

    // Reset in the middle of a read's WAIT phase
    ren[1] = 1'b1; wen[1] = 4'b0000; adr[1] = 32'h0000_0010;
    tick(); tick(); tick();
    rst = 1'b1;
    ren[1] = 1'b0;
    #1;
    check_idle_outputs(1, "midrst");
    check("midrst_rdat0", rdat[0], 32'h0);
    last_rdat[0] = '0;
    last_rdat[1] = '0;
    tick(); tick();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rdy[1] === 1'b1) pulses++;
    end
    check("midrst_no_rdy", 32'(pulses), 32'h0);
    xact(1, 1'b1, 4'b0000, 32'h0000_0010, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
